// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) followed by opcode-specific execute steps (T3-T7).
// Optional multiply/divide sequences are enabled by defining CONTROL_MULDIV_EN.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        pc_out,
  output logic        z_high_out,
  output logic        z_low_out,
  output logic        mdr_out,
  output logic        ba_out,
  output logic        c_out,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        outport_in,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic        inc_pc,
  output logic        read,
  output logic        write,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALTED
  } state_t;

  typedef enum logic [3:0] {
    K_ALU_R, K_ALU_I, K_UNARY, K_LDI, K_LD, K_ST, K_OUT,
    K_NOP, K_HALT, K_MULDIV, K_BAD
  } iclass_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b0100;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_ROR = 4'b0110;
  localparam logic [3:0] ALU_ROL = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;
  localparam logic [3:0] ALU_NEG = 4'b1010;
  localparam logic [3:0] ALU_NOT = 4'b1011;

  state_t      state_reg, state_next;
  logic        illegal_reg, illegal_next;
  iclass_t     iclass;
  logic [3:0]  op_alu;
  logic [4:0]  opcode;
  logic        unused_ir_bits;

  assign opcode         = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= T0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
    end
  end

  // Opcode decode into an instruction class plus the ALU function it uses.
  always_comb begin
    iclass = K_BAD;
    op_alu = ALU_AND;
    case (opcode)
      5'b00000: iclass = K_LD;
      5'b00001: iclass = K_LDI;
      5'b00010: iclass = K_ST;
      5'b00011: begin iclass = K_ALU_R; op_alu = ALU_ADD; end
      5'b00100: begin iclass = K_ALU_R; op_alu = ALU_SUB; end
      5'b00101: begin iclass = K_ALU_R; op_alu = ALU_SHR; end
      5'b00110: begin iclass = K_ALU_R; op_alu = ALU_SHL; end
      5'b00111: begin iclass = K_ALU_R; op_alu = ALU_ROR; end
      5'b01000: begin iclass = K_ALU_R; op_alu = ALU_ROL; end
      5'b01001: begin iclass = K_ALU_R; op_alu = ALU_AND; end
      5'b01010: begin iclass = K_ALU_R; op_alu = ALU_OR;  end
      5'b01011: begin iclass = K_ALU_I; op_alu = ALU_ADD; end
      5'b01100: begin iclass = K_ALU_I; op_alu = ALU_AND; end
      5'b01101: begin iclass = K_ALU_I; op_alu = ALU_OR;  end
`ifdef CONTROL_MULDIV_EN
      5'b01110: begin iclass = K_MULDIV; op_alu = ALU_MUL; end
      5'b01111: begin iclass = K_MULDIV; op_alu = ALU_DIV; end
`endif
      5'b10000: begin iclass = K_UNARY; op_alu = ALU_NEG; end
      5'b10001: begin iclass = K_UNARY; op_alu = ALU_NOT; end
      5'b10110: iclass = K_OUT;
      5'b11001: iclass = K_NOP;
      5'b11010: iclass = K_HALT;
      default:  iclass = K_BAD;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    pc_out       = 1'b0;
    z_low_out    = 1'b0;
    mdr_out      = 1'b0;
    ba_out       = 1'b0;
    c_out        = 1'b0;
    pc_in        = 1'b0;
    ir_in        = 1'b0;
    mar_in       = 1'b0;
    mdr_in       = 1'b0;
    y_in         = 1'b0;
    z_in         = 1'b0;
    outport_in   = 1'b0;
    gra          = 1'b0;
    grb          = 1'b0;
    grc          = 1'b0;
    r_in         = 1'b0;
    r_out        = 1'b0;
    inc_pc       = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    alu_op       = ALU_AND;
`ifdef CONTROL_MULDIV_EN
    z_high_out   = 1'b0;
    hi_in        = 1'b0;
    lo_in        = 1'b0;
`endif
    case (state_reg)
      T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        alu_op = ALU_ADD;
        state_next = T1;
      end
      // The incremented PC in Z is committed only once the fetch read completes.
      T1: begin
        z_low_out = 1'b1; read = 1'b1; mdr_in = 1'b1;
        if (mem_ready) begin
          pc_in      = 1'b1;
          state_next = T2;
        end
      end
      T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        case (iclass)
          K_NOP:   state_next = T0;
          K_HALT:  state_next = HALTED;
          K_BAD: begin
            illegal_next = 1'b1;
            state_next   = HALTED;
          end
          default: state_next = T3;
        endcase
      end
      T3: begin
        state_next = T0;
        case (iclass)
          K_ALU_R, K_ALU_I, K_MULDIV: begin
            grb = 1'b1; r_out = 1'b1; y_in = 1'b1; state_next = T4;
          end
          K_UNARY: begin
            grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = op_alu;
            state_next = T4;
          end
          K_LDI, K_LD, K_ST: begin
            grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; state_next = T4;
          end
          K_OUT: begin
            gra = 1'b1; r_out = 1'b1; outport_in = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        state_next = T0;
        case (iclass)
          K_ALU_R, K_MULDIV: begin
            grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = op_alu;
            state_next = T5;
          end
          K_ALU_I: begin
            c_out = 1'b1; z_in = 1'b1; alu_op = op_alu; state_next = T5;
          end
          K_UNARY: begin
            z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1;
          end
          K_LDI, K_LD, K_ST: begin
            c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; state_next = T5;
          end
          default: ;
        endcase
      end
      T5: begin
        state_next = T0;
        case (iclass)
          K_ALU_R, K_ALU_I, K_LDI: begin
            z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1;
          end
          K_LD, K_ST: begin
            z_low_out = 1'b1; mar_in = 1'b1; state_next = T6;
          end
`ifdef CONTROL_MULDIV_EN
          K_MULDIV: begin
            z_low_out = 1'b1; lo_in = 1'b1; state_next = T6;
          end
`endif
          default: ;
        endcase
      end
      T6: begin
        state_next = T0;
        case (iclass)
          K_LD: begin
            read = 1'b1; mdr_in = 1'b1;
            state_next = mem_ready ? T7 : T6;
          end
          K_ST: begin
            gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; state_next = T7;
          end
`ifdef CONTROL_MULDIV_EN
          K_MULDIV: begin
            z_high_out = 1'b1; hi_in = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      T7: begin
        state_next = T0;
        case (iclass)
          K_LD: begin
            mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
          end
          K_ST: begin
            write = 1'b1;
            state_next = mem_ready ? T0 : T7;
          end
          default: ;
        endcase
      end
      HALTED:  state_next = HALTED;
      default: state_next = T0;
    endcase
  end

`ifndef CONTROL_MULDIV_EN
  assign z_high_out = 1'b0;
  assign hi_in      = 1'b0;
  assign lo_in      = 1'b0;
`endif

  assign run     = (state_reg != HALTED);
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: all outputs are packed into one word and compared per cycle.
module tb_control_sequencer;

  logic        clk, reset, mem_ready;
  logic [31:0] ir;
  logic pc_out, z_high_out, z_low_out, mdr_out, ba_out, c_out;
  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in;
  logic gra, grb, grc, r_in, r_out, inc_pc, read, write, run, illegal;
  logic [3:0] alu_op;

  control_sequencer dut (
    .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .z_high_out(z_high_out), .z_low_out(z_low_out),
    .mdr_out(mdr_out), .ba_out(ba_out), .c_out(c_out),
    .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .outport_in(outport_in), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .inc_pc(inc_pc), .read(read),
    .write(write), .alu_op(alu_op), .run(run), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [28:0] PC_OUT     = 29'd1 << 28;
  localparam logic [28:0] Z_HIGH_OUT = 29'd1 << 27;
  localparam logic [28:0] Z_LOW_OUT  = 29'd1 << 26;
  localparam logic [28:0] MDR_OUT    = 29'd1 << 25;
  localparam logic [28:0] BA_OUT     = 29'd1 << 24;
  localparam logic [28:0] C_OUT      = 29'd1 << 23;
  localparam logic [28:0] PC_IN      = 29'd1 << 22;
  localparam logic [28:0] IR_IN      = 29'd1 << 21;
  localparam logic [28:0] MAR_IN     = 29'd1 << 20;
  localparam logic [28:0] MDR_IN     = 29'd1 << 19;
  localparam logic [28:0] Y_IN       = 29'd1 << 18;
  localparam logic [28:0] Z_IN       = 29'd1 << 17;
  localparam logic [28:0] HI_IN      = 29'd1 << 16;
  localparam logic [28:0] LO_IN      = 29'd1 << 15;
  localparam logic [28:0] OUTPORT_IN = 29'd1 << 14;
  localparam logic [28:0] GRA        = 29'd1 << 13;
  localparam logic [28:0] GRB        = 29'd1 << 12;
  localparam logic [28:0] GRC        = 29'd1 << 11;
  localparam logic [28:0] R_IN       = 29'd1 << 10;
  localparam logic [28:0] R_OUT      = 29'd1 << 9;
  localparam logic [28:0] INC_PC     = 29'd1 << 8;
  localparam logic [28:0] READ       = 29'd1 << 7;
  localparam logic [28:0] WRITE      = 29'd1 << 6;
  localparam logic [28:0] RUN        = 29'd1 << 1;
  localparam logic [28:0] ILLEGAL    = 29'd1;

  function automatic logic [28:0] alu(input logic [3:0] op);
    return {23'd0, op, 2'b00};
  endfunction

  logic [28:0] obs;
  assign obs = {pc_out, z_high_out, z_low_out, mdr_out, ba_out, c_out,
                pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in,
                gra, grb, grc, r_in, r_out, inc_pc, read, write, alu_op, run, illegal};

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [28:0] observed, input logic [28:0] expected);
    n_vec++;
    if (observed !== expected) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One control step: sample mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [28:0] expected);
    logic bus_ok;
    @(negedge clk);
    check(tag, obs, expected);
    bus_ok = !(read && write) &&
             ($countones({pc_out, z_high_out, z_low_out, mdr_out, ba_out, c_out}) <= 1);
    check({tag, "_excl"}, {28'd0, bus_ok}, 29'd1);
    @(posedge clk);
    #1;
  endtask

  localparam logic [28:0] E_T0 = PC_OUT | MAR_IN | INC_PC | Z_IN | (29'd2 << 2) | RUN;
  localparam logic [28:0] E_T1 = Z_LOW_OUT | READ | MDR_IN | RUN;
  localparam logic [28:0] E_T2 = MDR_OUT | IR_IN | RUN;
  localparam logic [28:0] E_T3_MEM = GRB | BA_OUT | Y_IN | RUN;
  localparam logic [28:0] E_T4_MEM = C_OUT | Z_IN | (29'd2 << 2) | RUN;
  localparam logic [28:0] E_T5_MEM = Z_LOW_OUT | MAR_IN | RUN;

  task automatic fetch(input string name, input logic [31:0] v);
    ir = v;
    mem_ready = 1'b1;
    $display("instr %s ir=%h", name, v);
    cyc({name, "_T0"}, E_T0);
    cyc({name, "_T1"}, E_T1 | PC_IN);
    cyc({name, "_T2"}, E_T2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; ir = 32'd0;
    @(posedge clk);
    #1;
    cyc("reset_hold", E_T0);
    reset = 1'b0;

    // ori R2,R1,$26
    fetch("ori", 32'h69080026);
    cyc("ori_T3", GRB | R_OUT | Y_IN | RUN);
    cyc("ori_T4", C_OUT | Z_IN | alu(4'b0001) | RUN);
    cyc("ori_T5", Z_LOW_OUT | GRA | R_IN | RUN);

    // sub with a stalled fetch read
    ir = 32'h20900000;
    $display("instr sub_wait ir=%h", ir);
    cyc("sub_T0", E_T0);
    mem_ready = 1'b0;
    cyc("sub_T1w0", E_T1);
    cyc("sub_T1w1", E_T1);
    cyc("sub_T1w2", E_T1);
    mem_ready = 1'b1;
    cyc("sub_T1go", E_T1 | PC_IN);
    cyc("sub_T2", E_T2);
    cyc("sub_T3", GRB | R_OUT | Y_IN | RUN);
    cyc("sub_T4", GRC | R_OUT | Z_IN | alu(4'b0011) | RUN);
    cyc("sub_T5", Z_LOW_OUT | GRA | R_IN | RUN);

    fetch("ld", 32'h00800010);
    cyc("ld_T3", E_T3_MEM);
    cyc("ld_T4", E_T4_MEM);
    cyc("ld_T5", E_T5_MEM);
    cyc("ld_T6", READ | MDR_IN | RUN);
    cyc("ld_T7", MDR_OUT | GRA | R_IN | RUN);

    fetch("st", 32'h10800010);
    cyc("st_T3", E_T3_MEM);
    cyc("st_T4", E_T4_MEM);
    cyc("st_T5", E_T5_MEM);
    cyc("st_T6", GRA | R_OUT | MDR_IN | RUN);
    cyc("st_T7", WRITE | RUN);

    fetch("neg", 32'h80800000);
    cyc("neg_T3", GRB | R_OUT | Z_IN | alu(4'b1010) | RUN);
    cyc("neg_T4", Z_LOW_OUT | GRA | R_IN | RUN);

    fetch("out", 32'hB0800000);
    cyc("out_T3", GRA | R_OUT | OUTPORT_IN | RUN);

    fetch("nop", 32'hC8000000);

    // st aborted by reset while waiting on memory
    fetch("st_abort", 32'h10800010);
    cyc("sta_T3", E_T3_MEM);
    cyc("sta_T4", E_T4_MEM);
    cyc("sta_T5", E_T5_MEM);
    cyc("sta_T6", GRA | R_OUT | MDR_IN | RUN);
    mem_ready = 1'b0;
    cyc("sta_T7w0", WRITE | RUN);
    cyc("sta_T7w1", WRITE | RUN);
    reset = 1'b1;
    cyc("sta_T7rst", WRITE | RUN);
    reset = 1'b0;
    mem_ready = 1'b1;
    cyc("sta_after_rst", E_T0);
    cyc("sta_after_T1", E_T1 | PC_IN);
    do_reset();

    fetch("mul", 32'h70800000);
`ifdef CONTROL_MULDIV_EN
    cyc("mul_T3", GRB | R_OUT | Y_IN | RUN);
    cyc("mul_T4", GRC | R_OUT | Z_IN | alu(4'b1000) | RUN);
    cyc("mul_T5", Z_LOW_OUT | LO_IN | RUN);
    cyc("mul_T6", Z_HIGH_OUT | HI_IN | RUN);
    cyc("mul_next", E_T0);
`else
    cyc("mul_illegal0", ILLEGAL);
    cyc("mul_illegal1", ILLEGAL);
`endif
    do_reset();

    fetch("halt", 32'hD0000000);
    cyc("halt_0", 29'd0);
    cyc("halt_1", 29'd0);
    cyc("halt_2", 29'd0);
    do_reset();

    fetch("bad", 32'hF8000000);
    for (int i = 0; i < 10; i++) cyc($sformatf("bad_halt%0d", i), ILLEGAL);
    do_reset();
    cyc("bad_cleared", E_T0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 No parameters; opcode, state and ALU-op encodings fixed as below.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ir  input  32  instruction register contents; opcode = ir[31:27].
REQ-005 mem_ready  input  1  memory done; completes the current read/write step.
REQ-006 pc_out, z_high_out, z_low_out, mdr_out, ba_out, c_out  output  1 each  bus-drive strobes.
REQ-007 pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in  output  1 each  register-load strobes.
REQ-008 gra, grb, grc, r_in, r_out  output  1 each  general-register select/load/drive.
REQ-009 inc_pc, read, write  output  1 each  PC-increment ALU mode, memory read, memory write.
REQ-010 alu_op  output  4  And 0000, Or 0001, Add 0010, Sub 0011, Shr 0100, Shl 0101, Ror 0110, Rol 0111, Mul 1000, Div 1001, Neg 1010, Not 1011.
REQ-011 run  output  1  high while sequencing; low in HALTED.
REQ-012 illegal  output  1  sticky; set on an undecoded opcode.

Function
REQ-013 States: T0..T7, HALTED; one control step per clk; outputs combinational from state and ir[31:27] only; unlisted strobes 0, alu_op 0000 unless stated.
REQ-014 T0: pc_out, mar_in, inc_pc, z_in, alu_op=Add; -> T1.
REQ-015 T1: z_low_out, read, mdr_in; pc_in only when mem_ready=1; stay in T1 while mem_ready=0; else -> T2.
REQ-016 T2: mdr_out, ir_in; -> T3, except nop (11001) -> T0, halt (11010) -> HALTED.
REQ-017 Reg ALU add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010: T3 grb,r_out,y_in; T4 grc,r_out,z_in,alu_op; T5 z_low_out,gra,r_in; -> T0.
REQ-018 Immediate addi 01011, andi 01100, ori 01101: as REQ-017 but T4 drives c_out instead of grc,r_out.
REQ-019 neg 10000, not 10001: T3 grb,r_out,z_in,alu_op; T4 z_low_out,gra,r_in; -> T0.
REQ-020 ldi 00001: T3 grb,ba_out,y_in; T4 c_out,z_in,Add; T5 z_low_out,gra,r_in; -> T0.
REQ-021 ld 00000: T3,T4 as ldi; T5 z_low_out,mar_in; T6 read,mdr_in, hold while mem_ready=0; T7 mdr_out,gra,r_in; -> T0.
REQ-022 st 00010: T3,T4 as ldi; T5 z_low_out,mar_in; T6 gra,r_out,mdr_in; T7 write, hold while mem_ready=0; -> T0.
REQ-023 out 10110: T3 gra,r_out,outport_in; -> T0.
REQ-024 Any other opcode at T2: illegal<=1, -> HALTED.
REQ-025 HALTED: all strobes 0, run=0; leaves only via reset.
REQ-026 write and read never both high; at most one bus-drive strobe high per cycle.

Reset
REQ-027 reset=1 at a clk edge: state<=T0, illegal<=0, run=1; overrides any state, including mem_ready waits.
REQ-028 Reset mid-instruction aborts it; first post-reset cycle asserts T0 strobes.

Configuration
REQ-029 CONTROL_MULDIV_EN defined: mul 01110/div 01111 run T3 grb,r_out,y_in; T4 grc,r_out,z_in,alu_op; T5 z_low_out,lo_in; T6 z_high_out,hi_in; -> T0.
REQ-030 CONTROL_MULDIV_EN undefined: mul/div follow REQ-024; hi_in, lo_in, z_high_out tied 0.

Verification
REQ-031 Reset, mem_ready=1, ir=0x69080026 (ori R2,R1,$26) -> T0..T5 strobes per REQ-014/015/016/018, alu_op=0001 at T4, back to T0 on the 7th cycle.
REQ-032 mem_ready low 3 cycles in T1 -> T1 held 4 cycles, pc_in high only in the final one, no state advance.
REQ-033 ld then st, mem_ready=1 -> 8-cycle sequences; write high only in st T7; read high only in T1 and ld T6.
REQ-034 ir opcode 11111 -> illegal=1, run=0 from the cycle after T2; strobes stay 0 for 10 cycles; reset clears both.
REQ-035 reset asserted during st T7 wait -> next cycle T0 strobes, write=0.
REQ-036 ir opcode 01110 -> with CONTROL_MULDIV_EN: lo_in at T5, hi_in at T6; without: illegal=1.
